gpio_checkpoint_monitor: RTL and testbench

- Synthesizable checker for user-project GPIO (mprj_io) progress signatures, driven by the firmware under test.
- Tracks an ordered list of expected values on a probe bus, requiring each to be held stable for a debounce window.
- Flags pass, fail or timeout, with a parametrised watchdog replacing fixed cycle budgets.
- Used in jacaranda-8 chip-level benches and reusable as an on-chip self-test observer.

---
 rtl/gpio_checkpoint_monitor.sv | 204 ++++++++++++++++++++
 tb/tb_gpio_checkpoint_monitor.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/gpio_checkpoint_monitor.sv
// gpio_checkpoint_monitor
//
// Watches a GPIO probe bus for an ordered list of progress signatures written
// by the firmware under test. Each probe value must be held for STABLE_CYCLES
// consecutive cycles before it is accepted. An accepted value that equals the
// next expected checkpoint advances the index. A watchdog counted from run
// start ends the run with a timeout.
//
// Build option: GPIO_MON_STRICT_ORDER_EN
//   When this is defined, an accepted value that equals a later checkpoint,
//   and not the current one, ends the run in DONE_FAIL.
//   When it is undefined, such values are ignored and fail is tied low.
//
// Ports:
//   clock          in   system clock
//   resetb         in   synchronous active-low reset
//   enable         in   1 = run, 0 = abort / return to IDLE
//   probe          in   observed GPIO bits [WIDTH]
//   expect_vec     in   checkpoint k at [k*WIDTH +: WIDTH], latched at run start
//   busy           out  high while waiting for checkpoints
//   pass           out  sticky, all checkpoints matched in order
//   fail           out  sticky, strict-order violation (option only)
//   timeout        out  sticky, watchdog expired
//   checkpoint_idx out  number of checkpoints matched so far
//   cycle_count    out  cycles elapsed in the current run, saturating
//
// state          | meaning
// ---------------+-----------------------------------------------------------
// S_IDLE         | not running; outputs cleared; waiting for enable
// S_WAIT         | tracking probe stability and matching checkpoints
// S_DONE_PASS    | every checkpoint matched; outputs frozen until enable=0
// S_DONE_FAIL    | out-of-order checkpoint seen (strict build only)
// S_DONE_TIMEOUT | watchdog reached TIMEOUT_CYCLES before completion

module gpio_checkpoint_monitor #(
    parameter int WIDTH           = 8,
    parameter int NUM_CHECKPOINTS = 4,
    parameter int STABLE_CYCLES   = 4,
    parameter int TIMEOUT_CYCLES  = 70000
) (
    input  logic                                     clock,
    input  logic                                     resetb,
    input  logic                                     enable,
    input  logic [WIDTH-1:0]                         probe,
    input  logic [NUM_CHECKPOINTS*WIDTH-1:0]         expect_vec,
    output logic                                     busy,
    output logic                                     pass,
    output logic                                     fail,
    output logic                                     timeout,
    output logic [$clog2(NUM_CHECKPOINTS+1)-1:0]     checkpoint_idx,
    output logic [$clog2(TIMEOUT_CYCLES+1)-1:0]      cycle_count
);

    localparam int IW = $clog2(NUM_CHECKPOINTS + 1);
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int SW = $clog2(STABLE_CYCLES + 1);

    localparam logic [SW-1:0] STABLE_TC  = SW'(STABLE_CYCLES);
    localparam logic [CW-1:0] TIMEOUT_TC = CW'(TIMEOUT_CYCLES);
    localparam logic [IW-1:0] LAST_IDX   = IW'(NUM_CHECKPOINTS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_DONE_PASS,
        S_DONE_FAIL,
        S_DONE_TIMEOUT
    } state_t;

    state_t                             state_q, state_d;
    logic [NUM_CHECKPOINTS*WIDTH-1:0]   exp_q, exp_d;
    logic [WIDTH-1:0]                   last_q, last_d;
    logic [SW-1:0]                      stable_q, stable_d;
    logic [IW-1:0]                      idx_q, idx_d;
    logic [CW-1:0]                      cnt_q, cnt_d;

    logic                               same;
    logic [SW-1:0]                      stable_trk;
    logic                               accepted;
    logic [WIDTH-1:0]                   cp_cur;
    logic                               match;
    logic                               ahead;
    logic [CW-1:0]                      cnt_inc;

    always_ff @(posedge clock) begin
        if (!resetb) begin
            state_q  <= S_IDLE;
            exp_q    <= '0;
            last_q   <= '0;
            stable_q <= '0;
            idx_q    <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            exp_q    <= exp_d;
            last_q   <= last_d;
            stable_q <= stable_d;
            idx_q    <= idx_d;
            cnt_q    <= cnt_d;
        end
    end

    // Checkpoint currently being waited for.
    always_comb begin
        cp_cur = '0;
        for (int k = 0; k < NUM_CHECKPOINTS; k++) begin
            if (idx_q == IW'(k)) cp_cur = exp_q[k*WIDTH +: WIDTH];
        end
    end

    // Acceptance is the edge on which the stable count arrives at STABLE_CYCLES.
    // Once saturated on an unchanged value, the count stays there and cannot
    // accept again. A repeated checkpoint therefore needs the probe to change
    // in between.
    always_comb begin
        same       = (probe == last_q);
        stable_trk = SW'(1);
        if (same) begin
            stable_trk = (stable_q == STABLE_TC) ? stable_q : stable_q + SW'(1);
        end
        accepted = (stable_trk == STABLE_TC) && !(same && (stable_q == STABLE_TC));
        match    = accepted && (probe == cp_cur);
        cnt_inc  = (cnt_q == TIMEOUT_TC) ? cnt_q : cnt_q + CW'(1);
    end

`ifdef GPIO_MON_STRICT_ORDER_EN
    // A later checkpoint seen before the current one is an ordering violation.
    always_comb begin
        ahead = 1'b0;
        for (int k = 0; k < NUM_CHECKPOINTS; k++) begin
            if ((IW'(k) > idx_q) && (probe == exp_q[k*WIDTH +: WIDTH])) ahead = 1'b1;
        end
        ahead = ahead && accepted && (probe != cp_cur);
    end
`else
    assign ahead = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        exp_d    = exp_q;
        last_d   = last_q;
        stable_d = stable_q;
        idx_d    = idx_q;
        cnt_d    = cnt_q;

        case (state_q)
            S_IDLE: begin
                if (enable) begin
                    state_d  = S_WAIT;
                    exp_d    = expect_vec;
                    cnt_d    = '0;
                    idx_d    = '0;
                    stable_d = '0;
                end
            end

            S_WAIT: begin
                if (!enable) begin
                    state_d  = S_IDLE;
                    idx_d    = '0;
                    cnt_d    = '0;
                    stable_d = '0;
                end else begin
                    last_d   = probe;
                    stable_d = stable_trk;
                    cnt_d    = cnt_inc;
                    if (match) idx_d = idx_q + IW'(1);
                    // Completion on the watchdog's final cycle still counts as a pass.
                    if (match && (idx_q == LAST_IDX)) begin
                        state_d = S_DONE_PASS;
                    end else if (ahead) begin
                        state_d = S_DONE_FAIL;
                    end else if (cnt_inc == TIMEOUT_TC) begin
                        state_d = S_DONE_TIMEOUT;
                    end
                end
            end

            S_DONE_PASS, S_DONE_FAIL, S_DONE_TIMEOUT: begin
                if (!enable) begin
                    state_d  = S_IDLE;
                    idx_d    = '0;
                    cnt_d    = '0;
                    stable_d = '0;
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    assign busy           = (state_q == S_WAIT);
    assign pass           = (state_q == S_DONE_PASS);
    assign timeout        = (state_q == S_DONE_TIMEOUT);
`ifdef GPIO_MON_STRICT_ORDER_EN
    assign fail           = (state_q == S_DONE_FAIL);
`else
    assign fail           = 1'b0;
`endif
    assign checkpoint_idx = idx_q;
    assign cycle_count    = cnt_q;

endmodule

// File: tb/tb_gpio_checkpoint_monitor.sv
// tb_gpio_checkpoint_monitor
//
// Directed bench for gpio_checkpoint_monitor.
// Configuration: WIDTH=8, four checkpoints, STABLE_CYCLES=4, TIMEOUT_CYCLES=100.
// Inputs are applied before a rising edge. Outputs are sampled 1 time unit after it.

module tb_gpio_checkpoint_monitor;

    localparam int WIDTH = 8;
    localparam int NCP   = 4;
    localparam int TMO   = 100;

    logic                  clock = 1'b0;
    logic                  resetb;
    logic                  enable;
    logic [WIDTH-1:0]      probe;
    logic [NCP*WIDTH-1:0]  expect_vec;
    logic                  busy, pass, fail, timeout;
    logic [2:0]            checkpoint_idx;
    logic [6:0]            cycle_count;

    int n_tests = 0;
    int n_fail  = 0;

    gpio_checkpoint_monitor #(
        .WIDTH(WIDTH), .NUM_CHECKPOINTS(NCP), .STABLE_CYCLES(4), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clock(clock), .resetb(resetb), .enable(enable), .probe(probe),
        .expect_vec(expect_vec), .busy(busy), .pass(pass), .fail(fail),
        .timeout(timeout), .checkpoint_idx(checkpoint_idx), .cycle_count(cycle_count)
    );

    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL global_time_limit: simulation did not finish, required finish before 200000");
        $fatal(1);
    end

    typedef struct {
        logic       en;
        logic [7:0] pr;
        int         busy;
        int         pass;
        int         tmo;
        int         idx;
        int         cc;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(logic en, logic [7:0] pr, int b, int p, int t, int i, int c);
        vec_t v;
        v.en = en; v.pr = pr; v.busy = b; v.pass = p; v.tmo = t; v.idx = i; v.cc = c;
        vecs.push_back(v);
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(string name, int act, int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_all(string tag, int b, int p, int f, int t, int i, int c);
        chk({tag, " busy"},    int'(busy), b);
        chk({tag, " pass"},    int'(pass), p);
        chk({tag, " fail"},    int'(fail), f);
        chk({tag, " timeout"}, int'(timeout), t);
        chk({tag, " idx"},     int'(checkpoint_idx), i);
        chk({tag, " cycles"},  int'(cycle_count), c);
    endtask

    task automatic hold(logic [7:0] v, int n);
        probe = v;
        repeat (n) tick();
    endtask

    task automatic start(logic [7:0] v);
        enable = 1'b1;
        probe  = v;
        tick();
    endtask

    task automatic stop();
        enable = 1'b0;
        tick();
    endtask

    initial begin
        resetb     = 1'b0;
        enable     = 1'b0;
        probe      = 8'h00;
        expect_vec = {8'hA4, 8'hA3, 8'hA2, 8'hA1};

        // In-order pass with each value held for 6 cycles. Row k is WAIT edge k.
        add(1, 8'hA1, 1, 0, 0, 0, 0);
        add(1, 8'hA1, 1, 0, 0, 0, 1);
        add(1, 8'hA1, 1, 0, 0, 0, 2);
        add(1, 8'hA1, 1, 0, 0, 0, 3);
        add(1, 8'hA1, 1, 0, 0, 1, 4);
        add(1, 8'hA1, 1, 0, 0, 1, 5);
        add(1, 8'hA1, 1, 0, 0, 1, 6);
        add(1, 8'hA2, 1, 0, 0, 1, 7);
        add(1, 8'hA2, 1, 0, 0, 1, 8);
        add(1, 8'hA2, 1, 0, 0, 1, 9);
        add(1, 8'hA2, 1, 0, 0, 2, 10);
        add(1, 8'hA2, 1, 0, 0, 2, 11);
        add(1, 8'hA2, 1, 0, 0, 2, 12);
        add(1, 8'hA3, 1, 0, 0, 2, 13);
        add(1, 8'hA3, 1, 0, 0, 2, 14);
        add(1, 8'hA3, 1, 0, 0, 2, 15);
        add(1, 8'hA3, 1, 0, 0, 3, 16);
        add(1, 8'hA3, 1, 0, 0, 3, 17);
        add(1, 8'hA3, 1, 0, 0, 3, 18);
        add(1, 8'hA4, 1, 0, 0, 3, 19);
        add(1, 8'hA4, 1, 0, 0, 3, 20);
        add(1, 8'hA4, 1, 0, 0, 3, 21);
        add(1, 8'hA4, 0, 1, 0, 4, 22);
        add(1, 8'hA4, 0, 1, 0, 4, 22);
        add(1, 8'hA4, 0, 1, 0, 4, 22);
        add(0, 8'hA4, 0, 0, 0, 0, 0);

        // Reset state, with enable held low.
        repeat (2) tick();
        chk_all("reset", 0, 0, 0, 0, 0, 0);
        resetb = 1'b1;
        tick();
        chk_all("idle_hold", 0, 0, 0, 0, 0, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            enable = vecs[i].en;
            probe  = vecs[i].pr;
            tick();
            chk_all($sformatf("vec%0d", i), vecs[i].busy, vecs[i].pass, 0,
                    vecs[i].tmo, vecs[i].idx, vecs[i].cc);
        end

        // Glitch rejection: a 3-cycle A1 is not accepted; the next 4-cycle A1 is.
        start(8'h00);
        hold(8'hA1, 3);
        chk("glitch short idx", int'(checkpoint_idx), 0);
        hold(8'h00, 1);
        hold(8'hA1, 3);
        chk("glitch 3rd idx", int'(checkpoint_idx), 0);
        hold(8'hA1, 1);
        chk("glitch accept idx", int'(checkpoint_idx), 1);
        chk("glitch accept cycles", int'(cycle_count), 8);
        stop();

        // Abort after two checkpoints, then restart and complete the run.
        start(8'hA1);
        hold(8'hA1, 4);
        hold(8'hA2, 4);
        chk("abort pre idx", int'(checkpoint_idx), 2);
        chk("abort pre busy", int'(busy), 1);
        stop();
        chk_all("abort", 0, 0, 0, 0, 0, 0);
        start(8'hA1);
        hold(8'hA1, 4);
        hold(8'hA2, 4);
        hold(8'hA3, 4);
        hold(8'hA4, 4);
        chk_all("restart", 0, 1, 0, 0, 4, 16);
        stop();

        // Reset in the middle of a run.
        start(8'hA1);
        hold(8'hA1, 4);
        chk("midreset pre idx", int'(checkpoint_idx), 1);
        resetb = 1'b0;
        tick();
        chk_all("midreset", 0, 0, 0, 0, 0, 0);
        resetb = 1'b1;
        enable = 1'b0;
        tick();

        // Watchdog: only A1 is ever presented.
        start(8'hA1);
        hold(8'hA1, 99);
        chk_all("tmo pre", 1, 0, 0, 0, 1, 99);
        hold(8'hA1, 1);
        chk_all("tmo hit", 0, 0, 0, 1, 1, 100);
        hold(8'hA2, 5);
        chk_all("tmo frozen", 0, 0, 0, 1, 1, 100);
        stop();
        chk_all("tmo clear", 0, 0, 0, 0, 0, 0);

        // Final checkpoint accepted on the same edge that the watchdog expires.
        start(8'hA1);
        hold(8'hA1, 4);
        hold(8'hA2, 4);
        hold(8'hA3, 4);
        hold(8'h00, 84);
        hold(8'hA4, 4);
        chk_all("simul", 0, 1, 0, 0, 4, 100);
        stop();

        // The same run, but A4 starts one cycle later: the watchdog wins.
        start(8'hA1);
        hold(8'hA1, 4);
        hold(8'hA2, 4);
        hold(8'hA3, 4);
        hold(8'h00, 85);
        hold(8'hA4, 3);
        chk_all("late", 0, 0, 0, 1, 3, 100);
        stop();

        // Out-of-order A3 after A1.
        start(8'hA1);
        hold(8'hA1, 4);
        hold(8'hA3, 4);
`ifdef GPIO_MON_STRICT_ORDER_EN
        chk_all("strict", 0, 0, 1, 0, 1, 8);
        hold(8'hA2, 4);
        chk_all("strict frozen", 0, 0, 1, 0, 1, 8);
`else
        chk_all("order ignored", 1, 0, 0, 0, 1, 8);
        hold(8'hA2, 4);
        chk_all("order continue", 1, 0, 0, 0, 2, 12);
`endif
        stop();
        chk_all("final idle", 0, 0, 0, 0, 0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
